// File: rtl/forward_scoreboard.sv
// forward_scoreboard: multi-port operand bypass with a long-op scoreboard and stall counter
module forward_scoreboard #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int NUM_RD    = 2,
  parameter int NUM_STG   = 2,
  parameter int LOP_DEPTH = 4,
  parameter int CNT_W     = 16
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NUM_STG-1:0]        stg_en,
  input  logic [NUM_STG*ADDR_W-1:0] stg_addr,
  input  logic [NUM_STG*DATA_W-1:0] stg_data,
  input  logic [NUM_STG-1:0]        stg_rdy,
  input  logic [NUM_RD*ADDR_W-1:0]  rd_addr,
  input  logic [NUM_RD*DATA_W-1:0]  rd_data,
  output logic [NUM_RD*DATA_W-1:0]  fwd_data,
  output logic                      stall,
  input  logic                      lop_issue,
  input  logic [ADDR_W-1:0]         lop_issue_addr,
  output logic                      lop_issue_ready,
  input  logic                      lop_wb_en,
  input  logic [ADDR_W-1:0]         lop_wb_addr,
  input  logic [DATA_W-1:0]         lop_wb_data,
  input  logic                      flush,
  output logic [CNT_W-1:0]          stall_cnt
);
  logic [LOP_DEPTH-1:0] sb_valid, issue_dup, wb_clr, free, alloc;
  logic [ADDR_W-1:0]    sb_addr [LOP_DEPTH];
  logic [NUM_RD-1:0]    port_stall;
  logic                 do_alloc;
  always_comb begin
    issue_dup = '0;
    wb_clr    = '0;
    for (int k = 0; k < LOP_DEPTH; k++) begin
      issue_dup[k] = sb_valid[k] && sb_addr[k] == lop_issue_addr;
      wb_clr[k]    = lop_wb_en && sb_valid[k] && sb_addr[k] == lop_wb_addr;
    end
  end
  // lowest free entry as a one-hot mask
  assign free            = ~sb_valid;
  assign alloc           = free & (~free + LOP_DEPTH'(1));
  assign lop_issue_ready = |free && !(|issue_dup);
  assign do_alloc        = lop_issue && lop_issue_ready && |lop_issue_addr;
  for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] r, d;
    logic              hit, pend, s;
    assign a = rd_addr[j*ADDR_W +: ADDR_W];
    assign r = rd_data[j*DATA_W +: DATA_W];
    // walking from oldest to youngest lets the youngest matching stage win
    always_comb begin
      d    = r;
      s    = 1'b0;
      hit  = 1'b0;
      pend = 1'b0;
      for (int i = NUM_STG - 1; i >= 0; i--)
        if (stg_en[i] && stg_addr[i*ADDR_W +: ADDR_W] == a) begin
          hit = 1'b1;
          d   = stg_rdy[i] ? stg_data[i*DATA_W +: DATA_W] : r;
          s   = !stg_rdy[i];
        end
      for (int k = 0; k < LOP_DEPTH; k++)
        pend = pend | (sb_valid[k] && sb_addr[k] == a);
      if (!hit && lop_wb_en && lop_wb_addr == a) d = lop_wb_data;
      else if (!hit) s = pend;
      if (a == '0) begin
        d = '0;
        s = 1'b0;
      end
    end
    assign fwd_data[j*DATA_W +: DATA_W] = d;
    assign port_stall[j]                = s;
  end
  assign stall = |port_stall;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sb_valid  <= '0;
      stall_cnt <= '0;
    end else begin
      sb_valid <= flush ? '0 : (sb_valid & ~wb_clr) | (do_alloc ? alloc : '0);
      if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
  always_ff @(posedge clk)
    for (int k = 0; k < LOP_DEPTH; k++)
      if (do_alloc && alloc[k]) sb_addr[k] <= lop_issue_addr;
endmodule

// File: tb/tb_forward_scoreboard.sv
// tb_forward_scoreboard: vector table, directed corner sequences and randomized model check
module tb_forward_scoreboard;
  localparam int DW = 32, AW = 5, NR = 2, NS = 2, LD = 4, CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             resetn;
  logic [NS-1:0]    stg_en, stg_rdy;
  logic [NS*AW-1:0] stg_addr;
  logic [NS*DW-1:0] stg_data;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data, fwd_data;
  logic             stall, lop_issue, lop_issue_ready, lop_wb_en, flush;
  logic [AW-1:0]    lop_issue_addr, lop_wb_addr;
  logic [DW-1:0]    lop_wb_data;
  logic [CW-1:0]    stall_cnt;

  forward_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_STG(NS),
                       .LOP_DEPTH(LD), .CNT_W(CW)) dut (
    .clk(clk), .resetn(resetn), .stg_en(stg_en), .stg_addr(stg_addr),
    .stg_data(stg_data), .stg_rdy(stg_rdy), .rd_addr(rd_addr), .rd_data(rd_data),
    .fwd_data(fwd_data), .stall(stall), .lop_issue(lop_issue),
    .lop_issue_addr(lop_issue_addr), .lop_issue_ready(lop_issue_ready),
    .lop_wb_en(lop_wb_en), .lop_wb_addr(lop_wb_addr), .lop_wb_data(lop_wb_data),
    .flush(flush), .stall_cnt(stall_cnt));

  int total = 0, bad = 0;
  bit pend [32];
  int cnt = 0;

  typedef struct {
    logic [1:0]    en, rdy;
    logic [AW-1:0] a0, a1, r0, r1, wa;
    logic [DW-1:0] d0, d1, wd, e0, e1;
    logic          wb, es;
  } vec_t;
  vec_t tv [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic int npend();
    int n = 0;
    for (int a = 0; a < 32; a++) n += int'(pend[a]);
    return n;
  endfunction

  function automatic logic mready();
    return npend() < LD && !pend[lop_issue_addr];
  endfunction

  // reference: operand selection straight from the priority rules
  task automatic mport(input int j, output logic [DW-1:0] d, output logic s);
    logic [AW-1:0] a;
    logic [DW-1:0] r;
    logic found;
    a = rd_addr[j*AW +: AW];
    r = rd_data[j*DW +: DW];
    found = 1'b0;
    d = r;
    s = 1'b0;
    if (a == 0) begin
      d = '0;
      found = 1'b1;
    end
    for (int i = 0; i < NS; i++)
      if (!found && stg_en[i] && stg_addr[i*AW +: AW] == a) begin
        found = 1'b1;
        d = stg_rdy[i] ? stg_data[i*DW +: DW] : r;
        s = !stg_rdy[i];
      end
    if (!found && lop_wb_en && lop_wb_addr == a) begin
      found = 1'b1;
      d = lop_wb_data;
    end
    if (!found) s = pend[a];
  endtask

  task automatic check_all(input string tag);
    logic [DW-1:0] d;
    logic s, s_any;
    s_any = 1'b0;
    for (int j = 0; j < NR; j++) begin
      mport(j, d, s);
      s_any |= s;
      chk($sformatf("%s_fwd%0d", tag, j), fwd_data[j*DW +: DW], d);
    end
    chk({tag, "_stall"}, 32'(stall), 32'(s_any));
    chk({tag, "_ready"}, 32'(lop_issue_ready), 32'(mready()));
    chk({tag, "_cnt"}, 32'(stall_cnt), cnt);
  endtask

  task automatic step();
    logic [DW-1:0] d;
    logic s, s_any, rdy;
    if (lop_issue) chk("issue_ok", 32'(lop_issue_ready), 1);
    s_any = 1'b0;
    for (int j = 0; j < NR; j++) begin
      mport(j, d, s);
      s_any |= s;
    end
    rdy = mready();
    if (!resetn) begin
      pend = '{default: 0};
      cnt = 0;
    end else begin
      if (s_any && cnt < CMAX) cnt++;
      if (flush) pend = '{default: 0};
      else begin
        if (lop_wb_en) pend[lop_wb_addr] = 0;
        if (lop_issue && rdy && lop_issue_addr != 0) pend[lop_issue_addr] = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    resetn = 1'b1; stg_en = '0; stg_rdy = '1; stg_addr = '0; stg_data = '0;
    rd_addr = '0; rd_data = {32'h200, 32'h100}; lop_issue = 1'b0; lop_issue_addr = '0;
    lop_wb_en = 1'b0; lop_wb_addr = '0; lop_wb_data = '0; flush = 1'b0;
  endtask

  initial begin
    tv[0] = '{en:2'b11, rdy:2'b11, a0:5, a1:5, r0:5, r1:0, wa:0, d0:32'hA, d1:32'hB, wd:0,
              e0:32'hA, e1:0, wb:0, es:0};
    tv[1] = '{en:2'b01, rdy:2'b00, a0:7, a1:0, r0:3, r1:7, wa:0, d0:32'hA, d1:32'hB, wd:0,
              e0:32'h100, e1:32'h200, wb:0, es:1};
    tv[2] = '{en:2'b10, rdy:2'b11, a0:0, a1:9, r0:9, r1:9, wa:0, d0:32'hA, d1:32'hB, wd:0,
              e0:32'hB, e1:32'hB, wb:0, es:0};
    tv[3] = '{en:2'b11, rdy:2'b10, a0:4, a1:4, r0:4, r1:6, wa:0, d0:32'hA, d1:32'hB, wd:0,
              e0:32'h100, e1:32'h200, wb:0, es:1};
    tv[4] = '{en:2'b00, rdy:2'b11, a0:6, a1:6, r0:6, r1:2, wa:6, d0:32'hA, d1:32'hB, wd:32'h1234,
              e0:32'h1234, e1:32'h200, wb:1, es:0};
    tv[5] = '{en:2'b01, rdy:2'b11, a0:6, a1:0, r0:6, r1:0, wa:6, d0:32'hA, d1:32'hB, wd:32'h1234,
              e0:32'hA, e1:0, wb:1, es:0};
    tv[6] = '{en:2'b11, rdy:2'b00, a0:0, a1:0, r0:0, r1:0, wa:0, d0:32'hA, d1:32'hB, wd:32'h55,
              e0:0, e1:0, wb:1, es:0};

    clear_inputs();
    resetn = 1'b0;
    step();
    step();
    resetn = 1'b1;
    #1;
    chk("rst_ready", 32'(lop_issue_ready), 1);
    chk("rst_cnt", 32'(stall_cnt), 0);
    chk("rst_stall", 32'(stall), 0);

    for (int k = 0; k < 7; k++) begin
      stg_en = tv[k].en; stg_rdy = tv[k].rdy;
      stg_addr = {tv[k].a1, tv[k].a0}; stg_data = {tv[k].d1, tv[k].d0};
      rd_addr = {tv[k].r1, tv[k].r0}; rd_data = {32'h200, 32'h100};
      lop_wb_en = tv[k].wb; lop_wb_addr = tv[k].wa; lop_wb_data = tv[k].wd;
      #1;
      chk($sformatf("tv%0d_fwd0", k), fwd_data[DW-1:0], tv[k].e0);
      chk($sformatf("tv%0d_fwd1", k), fwd_data[2*DW-1:DW], tv[k].e1);
      chk($sformatf("tv%0d_stall", k), 32'(stall), 32'(tv[k].es));
      step();
    end
    clear_inputs();

    // held load-use stall counts once per cycle
    stg_en = 2'b01; stg_addr = {5'd0, 5'd7}; stg_rdy = 2'b10; rd_addr = {5'd7, 5'd0};
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("hold_cnt", 32'(stall_cnt), cnt);
      check_all("hold");
      step();
    end
    clear_inputs();

    // long op to r9: stall, writeback forwards, then freed
    lop_issue = 1'b1; lop_issue_addr = 9;
    #1;
    step();
    lop_issue = 1'b0; rd_addr = {5'd0, 5'd9};
    #1;
    chk("r9_stall", 32'(stall), 1);
    chk("r9_fwd", fwd_data[DW-1:0], 32'h100);
    step();
    lop_wb_en = 1'b1; lop_wb_addr = 9; lop_wb_data = 32'h1234;
    #1;
    chk("r9_wb_fwd", fwd_data[DW-1:0], 32'h1234);
    chk("r9_wb_stall", 32'(stall), 0);
    step();
    lop_wb_en = 1'b0;
    #1;
    chk("r9_free_stall", 32'(stall), 0);
    chk("r9_free_fwd", fwd_data[DW-1:0], 32'h100);
    check_all("r9");

    // fill all entries
    for (int k = 1; k <= 4; k++) begin
      lop_issue = 1'b1; lop_issue_addr = AW'(k);
      #1;
      step();
    end
    lop_issue = 1'b0; lop_issue_addr = 7;
    #1;
    chk("full_ready", 32'(lop_issue_ready), 0);
    lop_wb_en = 1'b1; lop_wb_addr = 2; lop_wb_data = 32'h22;
    step();
    lop_wb_en = 1'b0;
    #1;
    chk("after_wb_ready", 32'(lop_issue_ready), 1);
    check_all("fill");

    // duplicate issue, r0 reads, flush against issue
    flush = 1'b1;
    step();
    flush = 1'b0; lop_issue = 1'b1; lop_issue_addr = 3;
    #1;
    step();
    lop_issue = 1'b0;
    #1;
    chk("dup_ready", 32'(lop_issue_ready), 0);
    stg_en = 2'b11; stg_addr = '0; stg_rdy = 2'b00; rd_addr = '0;
    #1;
    chk("r0_fwd", fwd_data[DW-1:0], 0);
    chk("r0_stall", 32'(stall), 0);
    stg_en = '0; stg_rdy = '1;
    flush = 1'b1; lop_issue = 1'b1; lop_issue_addr = 12;
    #1;
    step();
    flush = 1'b0; lop_issue = 1'b0; lop_issue_addr = 3; rd_addr = {5'd12, 5'd3};
    #1;
    chk("flush_stall", 32'(stall), 0);
    chk("flush_ready", 32'(lop_issue_ready), 1);
    check_all("flush");

    // saturation then mid-run reset
    stg_en = 2'b01; stg_addr = {5'd0, 5'd7}; stg_rdy = 2'b10; rd_addr = {5'd7, 5'd0};
    #1;
    repeat (20) step();
    chk("sat_cnt", 32'(stall_cnt), CMAX);
    clear_inputs();
    lop_issue = 1'b1; lop_issue_addr = 5;
    #1;
    step();
    lop_issue = 1'b0; resetn = 1'b0;
    step();
    resetn = 1'b1; rd_addr = {5'd0, 5'd5};
    #1;
    chk("mrst_cnt", 32'(stall_cnt), 0);
    chk("mrst_stall", 32'(stall), 0);
    chk("mrst_ready", 32'(lop_issue_ready), 1);

    for (int n = 0; n < 400; n++) begin
      stg_en = NS'($urandom); stg_rdy = NS'($urandom);
      for (int i = 0; i < NS; i++) begin
        stg_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
        stg_data[i*DW +: DW] = $urandom;
      end
      for (int j = 0; j < NR; j++) begin
        rd_addr[j*AW +: AW] = AW'($urandom_range(0, 7));
        rd_data[j*DW +: DW] = $urandom;
      end
      lop_wb_en = $urandom_range(0, 2) == 0;
      lop_wb_addr = AW'($urandom_range(0, 7));
      lop_wb_data = $urandom;
      lop_issue_addr = AW'($urandom_range(0, 7));
      lop_issue = ($urandom_range(0, 2) == 0) && mready();
      flush = $urandom_range(0, 24) == 0;
      resetn = $urandom_range(0, 59) != 0;
      #1;
      check_all("rnd");
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/forward_scoreboard.md
# forward_scoreboard

Parametrised operand-bypass and hazard unit for the execute stage of the MIPS core. It extends plain EX/MEM forwarding to NUM_RD read ports and NUM_STG producer stages, each with a data-ready qualifier. It also keeps a small scoreboard of outstanding long-latency writes (divider, HI/LO-to-GPR, uncached loads), and raises a stall when an operand is not yet available. It sits between the register-file read outputs and the ALU operand muxes.

## Interface
- DATA_W, 32, datapath width
- ADDR_W, 5, register-number width
- NUM_RD, 2, operand read ports
- NUM_STG, 2, pipeline producer stages; index 0 is youngest (EX), index NUM_STG-1 is oldest
- LOP_DEPTH, 4, scoreboard entries for outstanding long ops (>=1)
- CNT_W, 16, stall-counter width
- clk  in  1  clock; all state updates on rising edge
- resetn  in  1  synchronous, active-low reset
- stg_en  in  NUM_STG  stage i writes a register
- stg_addr  in  NUM_STG*ADDR_W  destination of stage i (slice i)
- stg_data  in  NUM_STG*DATA_W  result of stage i
- stg_rdy  in  NUM_STG  stage i result is valid (0 for a load still in EX)
- rd_addr  in  NUM_RD*ADDR_W  register read by port j
- rd_data  in  NUM_RD*DATA_W  register-file value for port j
- fwd_data  out  NUM_RD*DATA_W  bypassed operand for port j
- stall  out  1  an operand is unavailable this cycle
- lop_issue  in  1  long op dispatched this cycle
- lop_issue_addr  in  ADDR_W  its destination register
- lop_issue_ready  out  1  scoreboard can accept lop_issue
- lop_wb_en  in  1  long-op result returns this cycle
- lop_wb_addr  in  ADDR_W  its destination
- lop_wb_data  in  DATA_W  its result
- flush  in  1  pipeline flush; discards outstanding long ops
- stall_cnt  out  CNT_W  saturating count of stalled cycles

## Operation
- Per read port j, evaluated combinationally:
  - rd_addr==0: fwd_data=0, never stalls.
  - Otherwise the lowest-index stage i with stg_en[i] && stg_addr[i]==rd_addr wins.
    - stg_rdy[i]=1: fwd_data=stg_data[i].
    - stg_rdy[i]=0: port stalls, and fwd_data=rd_data.
  - With no stage match, lop_wb_en && lop_wb_addr==rd_addr gives fwd_data=lop_wb_data, no stall.
  - With no stage or writeback match, a valid scoreboard entry with a matching address makes the port stall, with fwd_data=rd_data.
  - With no match of any kind, fwd_data=rd_data.
- stall = OR over all ports.
- Scoreboard: LOP_DEPTH entries, each holding {valid, addr}.
- lop_issue_ready = (some entry is free) && (no valid entry has addr==lop_issue_addr). It does not credit a same-cycle writeback.
- On lop_issue && lop_issue_ready && lop_issue_addr!=0, the lowest-index free entry is allocated.
- An issue to addr 0 is accepted but allocates nothing.
- An issue while lop_issue_ready=0 is a protocol violation: it is ignored, and the bench asserts it never happens.
- lop_wb_en clears the valid entry whose addr matches. A writeback with no matching entry still forwards and leaves the scoreboard unchanged.
- Writeback and issue in the same cycle: the clear and the allocation both take effect. If they target the same address, the result is one valid entry (a re-issue of a freed address is only legal when lop_issue_ready=1).
- flush clears every entry. Flush wins over issue and writeback in the same cycle.
- stall_cnt increments on each cycle with stall=1 and saturates at all-ones. Flush does not clear it.

## Timing
- fwd_data, stall and lop_issue_ready are combinational, with zero latency from their inputs.
- Scoreboard and stall_cnt change only at the rising edge of clk.
- An issued op is visible to the stall logic from the cycle after issue.
- A writeback forwards in its own cycle; the entry is gone from the next cycle.
- Reset (resetn=0 at an edge) clears all entries and sets stall_cnt=0.
  - After reset: lop_issue_ready=1, and stall=0 unless stages report stg_rdy=0 hits.
  - Reset mid-operation drops in-flight ops without any writeback being required.
- When all LOP_DEPTH entries are valid, lop_issue_ready=0 until a writeback or flush.

## Test plan
- Defaults, stg_en=2'b11, both stg_addr=5, stg_data=0xA/0xB, rd_addr[0]=5 -> fwd_data[0]=0xA (youngest wins), stall=0.
- stg_en[0]=1, stg_addr[0]=7, stg_rdy[0]=0, rd_addr[1]=7 -> stall=1, fwd_data[1]=rd_data[1]; stall_cnt increments by 1 per cycle held.
- Issue to r9. Next cycle, read r9 -> stall=1. A later lop_wb_en=1 for r9 with data 0x1234 -> fwd_data=0x1234, stall=0. Following cycle -> entry free, read r9 returns rd_data.
- Issue to r1..r4 on consecutive cycles (LOP_DEPTH=4) -> lop_issue_ready=0. A writeback for r2 -> lop_issue_ready=1 next cycle.
- Issue to r3, then issue to r3 again before its writeback -> lop_issue_ready=0. rd_addr=0 with matching stages gives 0 and no stall. Flush with issue in the same cycle -> scoreboard empty.
- Force stall_cnt to near saturation (CNT_W=4, 20 stall cycles) -> stall_cnt holds at 15. A mid-run resetn=0 at an edge -> stall_cnt=0, all entries freed.
